// File: rtl/tugemm_pkg.sv
// Shared definitions for the unary-counting NxN matrix multiplier:
// FSM state encoding and result-width helpers.
package tugemm_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_NEXT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Width of one result element; sized so that N products never overflow.
  function automatic int ow_f(input int w, input int n);
    return 2 * w + clog2_f(n);
  endfunction

endpackage

// File: rtl/tugemm_if.sv
// Request/result bundle of tugemm_nxn.
// Handshake: start is a request taken on a rising edge only while busy=0 and
// done=0 (IDLE); it is never queued. done pulses for one cycle when result is new.
interface tugemm_if #(
  parameter int N = 2,
  parameter int W = 8
);
  import tugemm_pkg::*;

  localparam int OW = ow_f(W, N);

  logic                  start;
  logic [N*N*W-1:0]      vector_a;
  logic [N*N*W-1:0]      vector_b;
  logic                  busy;
  logic                  done;
  logic [N*N*OW-1:0]     result;

  modport master (
    output start, vector_a, vector_b,
    input  busy, done, result
  );

  modport slave (
    input  start, vector_a, vector_b,
    output busy, done, result
  );

endinterface

// File: rtl/tugemm_pe.sv
// One output element: an OW-bit up/down unary accumulator with synchronous clear.
module tugemm_pe #(
  parameter int OW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          neg,
  output logic [OW-1:0] acc
);

  localparam logic [OW-1:0] ONE = OW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= neg ? acc - ONE : acc + ONE;
    end
  end

endmodule

// File: rtl/tugemm_nxn.sv
// NxN matrix multiply by unary counting: for each k, every a[i][k]*b[k][j]
// product is formed by stepping +/-1 over a |a| x |b| grid of (oc, ic) counts.
module tugemm_nxn
  import tugemm_pkg::*;
#(
  parameter int N           = 2,
  parameter int W           = 8,
  parameter int SIGNED_MODE = 1
) (
  input  logic     clk,
  input  logic     rst,
  tugemm_if.slave  bus,
  output state_t   dbg_state
);

  localparam int OW = ow_f(W, N);
  localparam int KW = clog2_f(N);

  state_t            state, state_nx;
  logic [N*N*W-1:0]  a_q, b_q;
  logic [KW-1:0]     k;
  logic [W-1:0]      oc, ic;
  logic [W-1:0]      ma, mb;
  logic [W-1:0]      mag_a [N];
  logic [W-1:0]      mag_b [N];
  logic [N-1:0]      neg_a, neg_b;
  logic              last_ic, last_oc;
  logic              acc_clr;
  logic [N*N*OW-1:0] acc_flat;
  logic [N*N*OW-1:0] result_q;

  // W-bit magnitude; the most negative value maps to 2^(W-1) without overflow.
  function automatic logic [W-1:0] mag_f(input logic [W-1:0] x);
    if (SIGNED_MODE != 0 && x[W-1]) return ~x + W'(1);
    return x;
  endfunction

  // Column k of A and row k of B, with their magnitudes, signs and maxima.
  always_comb begin
    ma    = '0;
    mb    = '0;
    neg_a = '0;
    neg_b = '0;
    for (int i = 0; i < N; i++) begin
      mag_a[i] = mag_f(a_q[(i*N + int'(k))*W +: W]);
      neg_a[i] = (SIGNED_MODE != 0) && a_q[(i*N + int'(k))*W + W - 1];
      if (mag_a[i] > ma) ma = mag_a[i];
    end
    for (int j = 0; j < N; j++) begin
      mag_b[j] = mag_f(b_q[(int'(k)*N + j)*W +: W]);
      neg_b[j] = (SIGNED_MODE != 0) && b_q[(int'(k)*N + j)*W + W - 1];
      if (mag_b[j] > mb) mb = mag_b[j];
    end
  end

  assign last_ic = (ic == mb - W'(1));
  assign last_oc = (oc == ma - W'(1));
  assign acc_clr = (state == S_IDLE) && bus.start;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (bus.start) state_nx = S_LOAD;
      S_LOAD: state_nx = (ma == '0 || mb == '0) ? S_NEXT : S_RUN;
      S_RUN:  if (last_oc && last_ic) state_nx = S_NEXT;
      S_NEXT: state_nx = (k == KW'(N - 1)) ? S_DONE : S_LOAD;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      k        <= '0;
      oc       <= '0;
      ic       <= '0;
      result_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            a_q <= bus.vector_a;
            b_q <= bus.vector_b;
            k   <= '0;
          end
        end
        S_LOAD: begin
          oc <= '0;
          ic <= '0;
        end
        S_RUN: begin
          if (last_ic) begin
            ic <= '0;
            oc <= oc + W'(1);
          end else begin
            ic <= ic + W'(1);
          end
        end
        S_NEXT: k <= k + KW'(1);
        default: ;
      endcase
      // result is only refreshed on entry to DONE and holds otherwise.
      if (state == S_NEXT && state_nx == S_DONE) result_q <= acc_flat;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic en;
      assign en = (state == S_RUN) && (oc < mag_a[i]) && (ic < mag_b[j]);
      tugemm_pe #(.OW(OW)) u_pe (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr),
        .en  (en),
        .neg (neg_a[i] ^ neg_b[j]),
        .acc (acc_flat[(i*N + j)*OW +: OW])
      );
    end
  end

  assign bus.busy   = (state == S_LOAD) || (state == S_RUN) || (state == S_NEXT);
  assign bus.done   = (state == S_DONE);
  assign bus.result = result_q;
  assign dbg_state  = state;

endmodule

// File: doc/tugemm_nxn.md
TUGEMM_NXN -- requirements
Module: tugemm_nxn

Interface
REQ-001 Parameter N, default 2: matrix dimension, N >= 2; A, B and C are NxN.
REQ-002 Parameter W, default 8: element width in bits.
REQ-003 Parameter SIGNED_MODE, default 1: 1 = two's-complement elements, 0 = unsigned elements.
REQ-004 Derived constant OW = 2*W + clog2(N): result element width.
REQ-005 clk  input  1: single clock; all state changes on the rising edge.
REQ-006 rst  input  1: asynchronous, active-low reset.
REQ-007 start  input  1: request a multiply; sampled only in IDLE.
REQ-008 vector_a  input  N*N*W: matrix A; element a[i][k] at bits [(i*N+k)*W +: W].
REQ-009 vector_b  input  N*N*W: matrix B; element b[k][j] at bits [(k*N+j)*W +: W].
REQ-010 busy  output  1: high in LOAD, RUN and NEXT.
REQ-011 done  output  1: one-cycle pulse, high only in DONE.
REQ-012 result  output  N*N*OW: C = A x B; c[i][j] at bits [(i*N+j)*OW +: OW], signed when SIGNED_MODE = 1.

Function
REQ-013 FSM states: IDLE, LOAD, RUN, NEXT, DONE.
REQ-014 IDLE with start = 1: on that edge, capture vector_a and vector_b, clear all accumulators, set k = 0, and go to LOAD; the inputs are ignored afterwards until DONE.
REQ-015 LOAD: compute ma_k = max over i of |a[i][k]| and mb_k = max over j of |b[k][j]|; clear counters oc and ic.
REQ-016 LOAD exit: go to NEXT if ma_k = 0 or mb_k = 0; otherwise go to RUN.
REQ-017 RUN, every cycle, for every (i,j): if oc < |a[i][k]| and ic < |b[k][j]|, add sgn(a[i][k])*sgn(b[k][j]) (+1 or -1) to acc[i][j]; otherwise acc[i][j] holds.
REQ-018 RUN counters: ic increments each cycle; when ic = mb_k-1, ic wraps to 0 and oc increments.
REQ-019 RUN exit: go to NEXT in the cycle where oc = ma_k-1 and ic = mb_k-1, so RUN lasts exactly ma_k*mb_k cycles.
REQ-020 NEXT: increment k; go to DONE if k = N-1, else go to LOAD.
REQ-021 DONE: lasts one cycle, copies acc into result on entry, asserts done, then returns to IDLE.
REQ-022 Latency: done rises Σk(2 + ma_k*mb_k) rising edges after the edge that accepts start.
REQ-023 SIGNED_MODE = 1: |x| of the most negative element is 2^(W-1) and is held in a W-bit magnitude without overflow.
REQ-024 SIGNED_MODE = 0: all elements are non-negative and sgn is always +1.
REQ-025 OW is sized so that no accumulation overflows, for any inputs, in either mode.
REQ-026 result holds its value from DONE until the next DONE; it does not change during a later operation.
REQ-027 start in LOAD, RUN, NEXT or DONE is ignored; it is not queued.
REQ-028 start held high continuously: a new operation begins on the first edge in IDLE after DONE.

Reset
REQ-029 rst = 0 forces state IDLE, busy = 0, done = 0, result = 0, accumulators = 0, and k, oc, ic = 0, asynchronously.
REQ-030 Reset mid-operation aborts the operation with no done pulse; the first start after reset release is accepted normally.

Structure
REQ-031 Shared package tugemm_pkg holds the FSM state encoding and the OW / clog2 width function.
REQ-032 Sub-module tugemm_pe is instantiated NxN times.
REQ-033 tugemm_pe contains one OW-bit accumulator with clear, an enable from the REQ-017 gating, and a step sign input.

Verification
REQ-034 N=2, W=8, signed; A=[[1,2],[3,4]] (vector_a=0x04030201), B=[[5,6],[7,8]] (vector_b=0x08070605) -> C=[[19,22],[43,50]]; done at edge 54 (18+32+4).
REQ-035 A=[[-1,2],[3,-4]], B=[[5,-6],[7,8]] -> C=[[9,22],[-13,-50]]; done at edge 54.
REQ-036 A = all zero, any B -> C = 0; done at edge 4 (2N).
REQ-037 A = B = all -128 -> every c = 32768; done at edge 32772.
REQ-038 start pulsed during RUN of the REQ-034 case -> ignored; one done pulse only; C unchanged.
REQ-039 rst asserted at edge 20 of REQ-034 -> outputs zero immediately and no done pulse; restart -> correct C at edge 54.
